rgb_pulse_gen: RTL and testbench



---
 rtl/rgb_pkg.sv | 23 ++
 rtl/rgb_pulse_gen_if.sv | 30 +++
 rtl/rgb_phase_cnt.sv | 38 +++
 rtl/rgb_pulse_gen.sv | 146 ++++++++++++++
 tb/tb_rgb_pulse_gen.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/rgb_pkg.sv
// Shared definitions for the WS2812-style LED line driver: FSM states,
// 50 MHz default timing and the per-LED bit count shared with rgb_data.
package rgb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_LATCH = 2'd3
  } rgb_state_e;

  localparam int DEF_T0H      = 20;
  localparam int DEF_T1H      = 40;
  localparam int DEF_TBIT     = 63;
  localparam int DEF_TRESET   = 2500;
  localparam int DEF_NUM_LEDS = 16;
  localparam int BITS_PER_LED = 24;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rgb_pulse_gen_if.sv
// Frame request, bit handshake and line outputs between the pulse
// generator and its neighbours; clock and reset stay plain ports.
interface rgb_pulse_gen_if;

  logic start;
  logic bitval;
  logic nextflag;
  logic dout;
  logic busy;
  logic done;

  modport master (
    output start,
    output bitval,
    input  nextflag,
    input  dout,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  bitval,
    output nextflag,
    output dout,
    output busy,
    output done
  );

endinterface

// File: rtl/rgb_phase_cnt.sv
// Loadable down-counter that times every HIGH, LOW and LATCH phase.
// Loading N-1 keeps the owning state active for exactly N cycles.
module rgb_phase_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc,
  output logic         tc_next
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // tc_next lets the owner register an output that coincides with the final phase cycle.
  assign tc      = (cnt_q == '0);
  assign tc_next = (cnt_d == '0);

endmodule

// File: rtl/rgb_pulse_gen.sv
// Renders each upstream bit as a high/low pulse on the LED line, then holds
// the line low for the latch gap and reports completion with done.
module rgb_pulse_gen
  import rgb_pkg::*;
#(
  parameter int T0H      = DEF_T0H,
  parameter int T1H      = DEF_T1H,
  parameter int TBIT     = DEF_TBIT,
  parameter int TRESET   = DEF_TRESET,
  parameter int NUM_LEDS = DEF_NUM_LEDS
) (
  input  logic           clk,
  input  logic           reset,
  rgb_pulse_gen_if.slave bus
);

  localparam int PW    = $clog2(max_int(TRESET, TBIT) + 1);
  localparam int NBITS = NUM_LEDS * BITS_PER_LED;
  localparam int BW    = $clog2(NBITS);

  localparam logic [PW-1:0] HI0_LD   = PW'(T0H - 1);
  localparam logic [PW-1:0] HI1_LD   = PW'(T1H - 1);
  localparam logic [PW-1:0] LO0_LD   = PW'(TBIT - T0H - 1);
  localparam logic [PW-1:0] LO1_LD   = PW'(TBIT - T1H - 1);
  localparam logic [PW-1:0] LAT_LD   = PW'(TRESET - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

  rgb_state_e    state_q;
  rgb_state_e    state_d;
  logic          cur_bit_q;
  logic          cur_bit_d;
  logic [BW-1:0] bit_cnt_q;
  logic [BW-1:0] bit_cnt_d;
  logic          dout_q;
  logic          dout_d;
  logic          busy_q;
  logic          busy_d;
  logic          nextflag_q;
  logic          nextflag_d;
  logic          done_q;
  logic          done_d;

  logic          ph_load;
  logic [PW-1:0] ph_load_val;
  logic          ph_tc;
  logic          ph_tc_next;

  rgb_phase_cnt #(
    .W (PW)
  ) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (ph_load),
    .load_val (ph_load_val),
    .tc       (ph_tc),
    .tc_next  (ph_tc_next)
  );

  // Next-state logic: every slot boundary samples bitval and reloads the phase counter.
  always_comb begin
    state_d     = state_q;
    cur_bit_d   = cur_bit_q;
    bit_cnt_d   = bit_cnt_q;
    ph_load     = 1'b0;
    ph_load_val = '0;

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (bus.start) begin
          cur_bit_d   = bus.bitval;
          state_d     = ST_HIGH;
          ph_load     = 1'b1;
          ph_load_val = bus.bitval ? HI1_LD : HI0_LD;
        end
      end

      ST_HIGH: begin
        if (ph_tc) begin
          state_d     = ST_LOW;
          ph_load     = 1'b1;
          ph_load_val = cur_bit_q ? LO1_LD : LO0_LD;
        end
      end

      ST_LOW: begin
        if (ph_tc) begin
          ph_load = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d     = ST_LATCH;
            ph_load_val = LAT_LD;
          end else begin
            bit_cnt_d   = bit_cnt_q + BW'(1);
            cur_bit_d   = bus.bitval;
            state_d     = ST_HIGH;
            ph_load_val = bus.bitval ? HI1_LD : HI0_LD;
          end
        end
      end

      ST_LATCH: begin
        if (ph_tc) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so that every one of them is a flop.
  always_comb begin
    dout_d     = (state_d == ST_HIGH);
    busy_d     = (state_d != ST_IDLE);
    nextflag_d = (state_d == ST_HIGH) && (state_q != ST_HIGH);
    done_d     = (state_d == ST_LATCH) && ph_tc_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cur_bit_q  <= 1'b0;
      bit_cnt_q  <= '0;
      dout_q     <= 1'b0;
      busy_q     <= 1'b0;
      nextflag_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_bit_q  <= cur_bit_d;
      bit_cnt_q  <= bit_cnt_d;
      dout_q     <= dout_d;
      busy_q     <= busy_d;
      nextflag_q <= nextflag_d;
      done_q     <= done_d;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.busy     = busy_q;
  assign bus.nextflag = nextflag_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_rgb_pulse_gen.sv
// Scoreboard bench for rgb_pulse_gen with small timing parameters: stimulus
// queues expected pulse widths and frame lengths, a monitor pops and compares.
module tb_rgb_pulse_gen;

  localparam int T0H       = 2;
  localparam int T1H       = 4;
  localparam int TBIT      = 6;
  localparam int TRESET    = 10;
  localparam int NUM_LEDS  = 1;
  localparam int NBITS     = 24;
  localparam int FRAME_LEN = 154;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rst_s = 1'b0;

  rgb_pulse_gen_if bus ();

  rgb_pulse_gen #(
    .T0H      (T0H),
    .T1H      (T1H),
    .TBIT     (TBIT),
    .TRESET   (TRESET),
    .NUM_LEDS (NUM_LEDS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_s <= reset;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_w[$];
  int   exp_frame[$];
  logic frame_bits [NBITS];
  int   bit_idx    = 0;
  int   cyc        = 0;
  int   rise_cyc   = 0;
  int   frame_rise = 0;
  logic prev_dout  = 1'b0;
  logic prev_busy  = 1'b0;

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Order: {dout, busy, nextflag, done}
  task automatic check_outs(input string name, input logic [3:0] exp);
    logic [3:0] act;
    act = {bus.dout, bus.busy, bus.nextflag, bus.done};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Upstream model: presents bit k until the k-th nextflag, then bit k+1.
  always @(negedge clk) begin
    if (bus.busy !== 1'b1) bit_idx = 0;
    else if (bus.nextflag === 1'b1) bit_idx++;
    bus.bitval = frame_bits[bit_idx % NBITS];
  end

  // Monitor: measures every pulse and frame and checks them against the queues.
  always @(negedge clk) begin
    cyc++;
    if (!rst_s) begin
      exp_w.delete();
      exp_frame.delete();
      prev_dout = 1'b0;
      prev_busy = 1'b0;
    end else begin
      check_bit("nextflag_at_rise", bus.nextflag, bus.dout && !prev_dout);
      if (bus.dout && !prev_dout) begin
        if (!prev_busy) frame_rise = cyc;
        else check_int("slot_period", cyc - rise_cyc, TBIT);
        rise_cyc = cyc;
      end
      if (!bus.dout && prev_dout) begin
        if (exp_w.size() == 0) check_int("unexpected_pulse", cyc - rise_cyc, 0);
        else check_int("high_width", cyc - rise_cyc, exp_w.pop_front());
      end
      if (bus.done === 1'b1) begin
        if (exp_frame.size() == 0) check_int("unexpected_done", cyc - frame_rise + 1, 0);
        else check_int("frame_len", cyc - frame_rise + 1, exp_frame.pop_front());
      end
      prev_dout = bus.dout;
      prev_busy = bus.busy;
    end
  end

  task automatic set_bits(input logic [7:0] b);
    for (int i = 0; i < NBITS; i++) frame_bits[i] = b[7 - (i % 8)];
  endtask

  task automatic push_exp();
    for (int i = 0; i < NBITS; i++) exp_w.push_back(frame_bits[i] ? T1H : T0H);
    exp_frame.push_back(FRAME_LEN);
  endtask

  // Called right after a negedge; start is sampled on the following posedge.
  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_outs("start_accept", 4'b1110);
  endtask

  task automatic wait_done(input bit poke_start);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_bit("done_seen", bus.done, 1'b1);
    if (poke_start) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_outs("after_done", 4'b0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    set_bits(8'h00);

    repeat (3) begin
      @(negedge clk);
      check_outs("reset_hold", 4'b0000);
    end
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_outs("idle_after_reset", 4'b0000);
    end

    // All-zero frame
    set_bits(8'h00);
    push_exp();
    do_start();
    wait_done(1'b0);
    @(negedge clk);
    check_outs("idle_between", 4'b0000);

    // 0x05 repeated: widths 2,2,2,2,2,4,2,4
    set_bits(8'h05);
    push_exp();
    do_start();
    wait_done(1'b0);
    @(negedge clk);

    // start while busy, and again in the done cycle
    set_bits(8'hC3);
    push_exp();
    do_start();
    repeat (19) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(1'b1);
    @(negedge clk);
    check_outs("no_restart", 4'b0000);

    // Mid-frame reset during bit 5 HIGH
    set_bits(8'h00);
    push_exp();
    do_start();
    repeat (30) @(negedge clk);
    check_bit("bit5_high", bus.dout, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check_outs("mid_reset", 4'b0000);
    reset = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check_outs("abandoned_frame", 4'b0000);
    end
    set_bits(8'hFF);
    push_exp();
    do_start();
    wait_done(1'b0);
    @(negedge clk);

    // Back-to-back frames with identical timing
    set_bits(8'h3C);
    push_exp();
    push_exp();
    do_start();
    wait_done(1'b0);
    do_start();
    wait_done(1'b0);

    repeat (3) @(negedge clk);
    check_int("width_queue_drained", exp_w.size(), 0);
    check_int("frame_queue_drained", exp_frame.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
